serial_tx: RTL and testbench

Parallel-to-serial transmitter. It drives the serial line that our flip-flop-based receive path samples.
- Accepts one DATA_W word per valid/ready handshake.
- Emits a frame on a single line: start bit (0), data LSB-first, optional even parity, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a parallel producer and the serial pin of the digital-logic lab datapath.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_tx_bit_timer.sv | 31 +++
 rtl/serial_tx.sv | 100 ++++++++++
 tb/tb_serial_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-line definitions for the transmit path and the matching receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Per-bit cycle counter; bit_done marks the last clock of the current serial bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_done = enable & (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= bit_done ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned BIT_W = cnt_w(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_parity;
  logic              w_accept;
  logic              w_timer_en;
  logic              w_bit_done;

  assign w_accept   = (r_state == IDLE) & tx_valid;
  assign w_timer_en = (r_state != IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (w_accept),
    .enable  (w_timer_en),
    .bit_done(w_bit_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = START;
      START:   if (w_bit_done) w_state_nxt = DATA;
      DATA: begin
        if (w_bit_done && (r_bit_cnt == LAST_BIT)) begin
          w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY:  if (w_bit_done) w_state_nxt = STOP;
      STOP:    if (w_bit_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word capture on accept, then shift out one bit per DATA bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= tx_data;
      r_bit_cnt <= '0;
      r_parity  <= ^tx_data;
    end else if ((r_state == DATA) && w_bit_done) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  always_comb begin
    tx_out   = LINE_IDLE;
    tx_ready = 1'b0;
    busy     = 1'b1;
    case (r_state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      START:   tx_out = START_BIT;
      DATA:    tx_out = r_shift[0];
      PARITY:  tx_out = r_parity;
      STOP:    tx_out = STOP_BIT;
      default: tx_out = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default, parity-enabled and one-clock-per-bit instances.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] v;
  logic [7:0] d [3];
  logic       line0, line1, line2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
  logic [2:0] line, rdy, bsy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign line = {line2, line1, line0};
  assign rdy  = {rdy2, rdy1, rdy0};
  assign bsy  = {bsy2, bsy1, bsy0};

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut (
    .clk(clk), .reset(reset), .tx_valid(v[0]), .tx_data(d[0]),
    .tx_ready(rdy0), .tx_out(line0), .busy(bsy0));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .clk(clk), .reset(reset), .tx_valid(v[1]), .tx_data(d[1]),
    .tx_ready(rdy1), .tx_out(line1), .busy(bsy1));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
    .clk(clk), .reset(reset), .tx_valid(v[2]), .tx_data(d[2]),
    .tx_ready(rdy2), .tx_out(line2), .busy(bsy2));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Each frame bit (LSB = first on the line) repeated cpb times.
  function automatic logic [127:0] expand(input logic [15:0] frame, input int nbits, input int cpb);
    logic [127:0] r = '0;
    for (int i = 0; i < nbits * cpb; i++) r[i] = frame[i / cpb];
    return r;
  endfunction

  // Called at a negedge; presents a word and returns at the negedge of the first start-bit cycle.
  task automatic send(input int s, input logic [7:0] val, input string tag);
    check({tag, "_ready"}, 128'(rdy[s]), 128'(1));
    v[s] = 1'b1;
    d[s] = val;
    @(negedge clk);
  endtask

  task automatic capture(input int s, input int n, input int chg_at, input logic [7:0] chg_val,
                         input int drop_at, output logic [127:0] cap, output int bc);
    cap = '0;
    bc  = 0;
    for (int k = 0; k < n; k++) begin
      if (k == chg_at) d[s] = chg_val;
      if (k == drop_at) v[s] = 1'b0;
      cap[k] = line[s];
      if (bsy[s] && !rdy[s]) bc++;
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    check({tag, "_idle_line"}, 128'(line[s]), 128'(1));
    check({tag, "_idle_ready"}, 128'(rdy[s]), 128'(1));
    check({tag, "_idle_busy"}, 128'(bsy[s]), 128'(0));
  endtask

  initial begin
    logic [127:0] cap;
    logic [127:0] exp;
    int           bc;
    int           start2;
    int           k;

    reset = 1'b0;
    v     = '0;
    for (int i = 0; i < 3; i++) d[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    check_idle(2, "rst2");
    reset = 1'b1;
    @(negedge clk);

    send(0, 8'hA5, "a5");
    capture(0, 40, -1, 8'h00, 0, cap, bc);
    check("a5_line", cap, expand({1'b1, 8'hA5, 1'b0}, 10, 4));
    check("a5_busy_cycles", 128'(bc), 128'(40));
    check_idle(0, "a5");

    send(1, 8'h07, "p07");
    capture(1, 44, -1, 8'h00, 0, cap, bc);
    check("p07_line", cap, expand({1'b1, 1'b1, 8'h07, 1'b0}, 11, 4));
    check("p07_parity_bit", 128'(cap[39:36]), 128'(4'hF));
    check("p07_busy_cycles", 128'(bc), 128'(44));
    check_idle(1, "p07");

    send(1, 8'h03, "p03");
    capture(1, 44, -1, 8'h00, 0, cap, bc);
    check("p03_line", cap, expand({1'b1, 1'b0, 8'h03, 1'b0}, 11, 4));
    check("p03_parity_bit", 128'(cap[39:36]), 128'(4'h0));
    check_idle(1, "p03");

    send(2, 8'h80, "f80");
    capture(2, 10, -1, 8'h00, 0, cap, bc);
    check("f80_line", cap, 128'(10'b11_0000_0000));
    check("f80_busy_cycles", 128'(bc), 128'(10));
    check_idle(2, "f80");

    // Valid held across the frame boundary: 0x00 then 0xFF.
    send(0, 8'h00, "b2b");
    capture(0, 81, 1, 8'hFF, 41, cap, bc);
    exp = expand({1'b1, 8'h00, 1'b0}, 10, 4) | (128'(1) << 40)
        | (expand({1'b1, 8'hFF, 1'b0}, 10, 4) << 41);
    check("b2b_line", cap, exp);
    check("b2b_busy_cycles", 128'(bc), 128'(80));
    start2 = -1;
    for (int i = 81; i >= 40; i--) if (cap[i] == 1'b0) start2 = i;
    check("b2b_second_start", 128'(start2), 128'(41));
    check_idle(0, "b2b");

    // Data changes mid-frame must not leak into the frame in flight.
    send(0, 8'hA5, "ign");
    capture(0, 81, 10, 8'h3C, 41, cap, bc);
    exp = expand({1'b1, 8'hA5, 1'b0}, 10, 4) | (128'(1) << 40)
        | (expand({1'b1, 8'h3C, 1'b0}, 10, 4) << 41);
    check("ign_line", cap, exp);
    check_idle(0, "ign");

    // Asynchronous reset in the middle of a frame.
    send(0, 8'h5A, "rmid");
    v[0] = 1'b0;
    k = int'($urandom_range(5, 35));
    repeat (k) @(negedge clk);
    check("rmid_busy_before", 128'(bsy[0]), 128'(1));
    #2 reset = 1'b0;
    #1;
    check("rmid_async_line", 128'(line[0]), 128'(1));
    check("rmid_async_busy", 128'(bsy[0]), 128'(0));
    check("rmid_async_ready", 128'(rdy[0]), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    capture(0, 10, -1, 8'h00, -1, cap, bc);
    check("rmid_line_quiet", cap, 128'(10'h3FF));
    check("rmid_busy_quiet", 128'(bc), 128'(0));

    send(0, 8'h96, "rec");
    capture(0, 40, -1, 8'h00, 0, cap, bc);
    check("rec_line", cap, expand({1'b1, 8'h96, 1'b0}, 10, 4));
    check_idle(0, "rec");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
